// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-oriented requesters.
// The owner keeps the transmitter across consecutive bytes until it releases or its lock times out.
module uart_tx_arbiter #(
    parameter int          NUM_REQ     = 4,
    parameter logic [15:0] LOCK_CYCLES = 16'd1000,
    parameter logic [3:0]  ACK_TIMEOUT = 4'd15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_tx_start,
    input  logic [8*NUM_REQ-1:0]   req_tx_data,
    input  logic [NUM_REQ-1:0]     req_release,
    output logic [NUM_REQ-1:0]     req_tx_busy,
    output logic [7:0]             uart_tx_data,
    output logic                   uart_tx_start,
    input  logic                   uart_tx_busy,
    output logic                   grant_valid,
    output logic [2:0]             grant_id,
    output logic                   err_overflow,
    output logic                   err_ack_timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;
    localparam logic [2:0] LAST_RST = 3'(NUM_REQ - 1);

    logic [1:0]             state, state_n;
    logic [NUM_REQ-1:0]     pend_valid, pend_valid_n;
    logic [8*NUM_REQ-1:0]   pend_data, pend_data_n;
    logic [2:0]             last_owner, last_owner_n;
    logic [2:0]             grant_id_n;
    logic                   grant_valid_n;
    logic [15:0]            lock_cnt, lock_cnt_n;
    logic [3:0]             ack_cnt, ack_cnt_n;
    logic                   rel_latched, rel_latched_n;
    logic                   start_n, ovf_n, tmo_n;
    logic [7:0]             data_n;
    logic [NUM_REQ-1:0]     busy_n;
    logic                   launch, owner_rel, owner_pend, found;
    logic [2:0]             launch_idx, winner;
    int                     scan_idx;

    always_comb begin
        state_n       = state;
        pend_valid_n  = pend_valid;
        pend_data_n   = pend_data;
        last_owner_n  = last_owner;
        grant_id_n    = grant_id;
        grant_valid_n = grant_valid;
        lock_cnt_n    = lock_cnt;
        ack_cnt_n     = ack_cnt;
        rel_latched_n = rel_latched;
        start_n       = 1'b0;
        data_n        = uart_tx_data;
        ovf_n         = err_overflow;
        tmo_n         = err_ack_timeout;
        launch        = 1'b0;
        launch_idx    = 3'd0;
        owner_rel     = 1'b0;
        owner_pend    = 1'b0;
        found         = 1'b0;
        winner        = 3'd0;
        scan_idx      = 0;
        busy_n        = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_tx_start[i]) begin
                if (pend_valid[i]) begin
                    ovf_n = 1'b1;
                end else begin
                    pend_valid_n[i]       = 1'b1;
                    pend_data_n[8*i +: 8] = req_tx_data[8*i +: 8];
                end
            end
            if (3'(i) == grant_id) begin
                owner_rel  = req_release[i];
                owner_pend = pend_valid[i];
            end
        end

        // Scan starts just after the previous owner, so it ends up last in line.
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = int'(last_owner) + k;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && i == scan_idx && pend_valid[i]) begin
                    found  = 1'b1;
                    winner = 3'(i);
                end
            end
        end

        case (state)
            ST_IDLE: begin
                if (found) begin
                    launch        = 1'b1;
                    launch_idx    = winner;
                    grant_id_n    = winner;
                    grant_valid_n = 1'b1;
                end
            end
            ST_SEND: begin
                if (owner_rel) rel_latched_n = 1'b1;
                if (uart_tx_busy) begin
                    state_n = ST_DRAIN;
                end else if (ack_cnt == ACK_TIMEOUT - 4'd1) begin
                    tmo_n      = 1'b1;
                    state_n    = ST_HOLD;
                    lock_cnt_n = LOCK_CYCLES;
                end else begin
                    ack_cnt_n = ack_cnt + 4'd1;
                end
            end
            ST_DRAIN: begin
                if (owner_rel) rel_latched_n = 1'b1;
                if (!uart_tx_busy) begin
                    if (rel_latched || owner_rel) begin
                        state_n       = ST_IDLE;
                        last_owner_n  = grant_id;
                        grant_valid_n = 1'b0;
                        rel_latched_n = 1'b0;
                    end else begin
                        state_n    = ST_HOLD;
                        lock_cnt_n = LOCK_CYCLES;
                    end
                end
            end
            ST_HOLD: begin
                if (owner_pend) begin
                    launch     = 1'b1;
                    launch_idx = grant_id;
                end else if (owner_rel || rel_latched || lock_cnt == 16'd0) begin
                    state_n       = ST_IDLE;
                    last_owner_n  = grant_id;
                    grant_valid_n = 1'b0;
                    rel_latched_n = 1'b0;
                end else begin
                    lock_cnt_n = lock_cnt - 16'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (launch) begin
            start_n       = 1'b1;
            state_n       = ST_SEND;
            ack_cnt_n     = 4'd0;
            rel_latched_n = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (3'(i) == launch_idx) begin
                    data_n          = pend_data[8*i +: 8];
                    pend_valid_n[i] = 1'b0;
                end
            end
        end

        // Busy is computed from next-state values so the registered copy tracks the state it describes.
        for (int i = 0; i < NUM_REQ; i++) begin
            busy_n[i] = pend_valid_n[i] |
                        (grant_valid_n & ((grant_id_n != 3'(i)) |
                                          (state_n == ST_SEND) | (state_n == ST_DRAIN)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            pend_valid      <= '0;
            pend_data       <= '0;
            last_owner      <= LAST_RST;
            grant_id        <= 3'd0;
            grant_valid     <= 1'b0;
            lock_cnt        <= 16'd0;
            ack_cnt         <= 4'd0;
            rel_latched     <= 1'b0;
            uart_tx_start   <= 1'b0;
            uart_tx_data    <= 8'd0;
            err_overflow    <= 1'b0;
            err_ack_timeout <= 1'b0;
            req_tx_busy     <= '0;
        end else begin
            state           <= state_n;
            pend_valid      <= pend_valid_n;
            pend_data       <= pend_data_n;
            last_owner      <= last_owner_n;
            grant_id        <= grant_id_n;
            grant_valid     <= grant_valid_n;
            lock_cnt        <= lock_cnt_n;
            ack_cnt         <= ack_cnt_n;
            rel_latched     <= rel_latched_n;
            uart_tx_start   <= start_n;
            uart_tx_data    <= data_n;
            err_overflow    <= ovf_n;
            err_ack_timeout <= tmo_n;
            req_tx_busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model that holds busy for 10 cycles per byte.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_tx_start;
    logic [31:0] req_tx_data;
    logic [3:0]  req_release;
    logic [3:0]  req_tx_busy;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_start;
    logic        uart_tx_busy;
    logic        grant_valid;
    logic [2:0]  grant_id;
    logic        err_overflow;
    logic        err_ack_timeout;
    logic        tie_low;
    int          byte_cnt;
    int          tests_run;
    int          tests_failed;

    uart_tx_arbiter #(.NUM_REQ(4), .LOCK_CYCLES(16'd1000), .ACK_TIMEOUT(4'd15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_tx_start(req_tx_start), .req_tx_data(req_tx_data), .req_release(req_release),
        .req_tx_busy(req_tx_busy), .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
        .uart_tx_busy(uart_tx_busy), .grant_valid(grant_valid), .grant_id(grant_id),
        .err_overflow(err_overflow), .err_ack_timeout(err_ack_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy rises the cycle after a start pulse and stays high for 10 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx_busy <= 1'b0;
            byte_cnt     <= 0;
        end else if (uart_tx_start && !tie_low) begin
            uart_tx_busy <= 1'b1;
            byte_cnt     <= 10;
        end else if (byte_cnt > 1) begin
            byte_cnt <= byte_cnt - 1;
        end else if (byte_cnt == 1) begin
            uart_tx_busy <= 1'b0;
            byte_cnt     <= 0;
        end
    end

    task automatic pulse(input logic [3:0] st, input logic [31:0] d, input logic [3:0] rel);
        @(negedge clk);
        req_tx_start = st;
        req_tx_data  = d;
        req_release  = rel;
        @(negedge clk);
        req_tx_start = 4'd0;
        req_release  = 4'd0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (uart_tx_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_busy_low(input int i, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_tx_busy[i] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (req_tx_busy !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0000", req_tx_busy); end
        tests_run++; if ({uart_tx_start, uart_tx_data} !== 9'd0) begin tests_failed++; $display("[TB] FAIL reset_tx: got %b/%h want 0/00", uart_tx_start, uart_tx_data); end
        tests_run++; if ({grant_valid, grant_id, err_overflow, err_ack_timeout} !== 6'd0) begin tests_failed++; $display("[TB] FAIL reset_grant: got %b want 000000", {grant_valid, grant_id, err_overflow, err_ack_timeout}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_contention;
        bit ok;
        pulse(4'b0101, 32'h00C0_00A0, 4'd0);
        tests_run++; if (req_tx_busy !== 4'b0101) begin tests_failed++; $display("[TB] FAIL cont_busy_c1: got %b want 0101", req_tx_busy); end
        @(negedge clk);
        tests_run++; if ({uart_tx_start, uart_tx_data, grant_id} !== {1'b1, 8'hA0, 3'd0}) begin tests_failed++; $display("[TB] FAIL cont_first: got %b/%h/%0d want 1/a0/0", uart_tx_start, uart_tx_data, grant_id); end
        tests_run++; if (req_tx_busy !== 4'b1111) begin tests_failed++; $display("[TB] FAIL cont_busy_c2: got %b want 1111", req_tx_busy); end
        wait_busy_low(0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL cont_hold_wait: got timeout want busy0 low"); end
        pulse(4'b0001, 32'h0000_00A1, 4'd0);
        @(negedge clk);
        tests_run++; if ({uart_tx_start, uart_tx_data, grant_id} !== {1'b1, 8'hA1, 3'd0}) begin tests_failed++; $display("[TB] FAIL cont_owner_second: got %b/%h/%0d want 1/a1/0", uart_tx_start, uart_tx_data, grant_id); end
        wait_busy_low(0, ok);
        pulse(4'd0, 32'd0, 4'b0001);
        wait_start(ok);
        tests_run++; if (!ok || uart_tx_data !== 8'hC0 || grant_id !== 3'd2) begin tests_failed++; $display("[TB] FAIL cont_r2: got ok=%b %h/%0d want 1 c0/2", ok, uart_tx_data, grant_id); end
        pulse(4'd0, 32'd0, 4'b0100);
        wait_busy_low(2, ok);
        tests_run++; if (!ok || grant_valid !== 1'b0 || grant_id !== 3'd2 || req_tx_busy !== 4'd0) begin tests_failed++; $display("[TB] FAIL cont_release_send: got ok=%b gv=%b id=%0d busy=%b want 1 0 2 0000", ok, grant_valid, grant_id, req_tx_busy); end
    endtask

    task automatic test_single;
        bit ok;
        pulse(4'b0010, 32'h0000_5300, 4'd0);
        tests_run++; if (req_tx_busy[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_busy_c1: got %b want 1", req_tx_busy[1]); end
        @(negedge clk);
        tests_run++; if ({uart_tx_start, uart_tx_data, grant_id} !== {1'b1, 8'h53, 3'd1}) begin tests_failed++; $display("[TB] FAIL single_first: got %b/%h/%0d want 1/53/1", uart_tx_start, uart_tx_data, grant_id); end
        wait_busy_low(1, ok);
        pulse(4'b0010, 32'h0000_2000, 4'd0);
        @(negedge clk);
        tests_run++; if ({uart_tx_start, uart_tx_data} !== {1'b1, 8'h20}) begin tests_failed++; $display("[TB] FAIL single_gap: got %b/%h want 1/20", uart_tx_start, uart_tx_data); end
        wait_busy_low(1, ok);
        tests_run++; if (!ok || req_tx_busy !== 4'b1101) begin tests_failed++; $display("[TB] FAIL single_hold_busy: got ok=%b %b want 1 1101", ok, req_tx_busy); end
        repeat (1000) @(negedge clk);
        tests_run++; if (grant_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_lock_held: got %b want 1", grant_valid); end
        @(negedge clk);
        tests_run++; if (grant_valid !== 1'b0 || grant_id !== 3'd1) begin tests_failed++; $display("[TB] FAIL single_lock_drop: got %b/%0d want 0/1", grant_valid, grant_id); end
    endtask

    task automatic test_release;
        bit ok;
        pulse(4'b1000, 32'h3300_0000, 4'd0);
        wait_start(ok);
        tests_run++; if (!ok || uart_tx_data !== 8'h33 || grant_id !== 3'd3) begin tests_failed++; $display("[TB] FAIL rel_r3: got ok=%b %h/%0d want 1 33/3", ok, uart_tx_data, grant_id); end
        repeat (2) @(negedge clk);
        pulse(4'b0010, 32'h0000_1100, 4'b1000);
        wait_busy_low(3, ok);
        tests_run++; if (!ok || grant_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rel_idle: got ok=%b gv=%b want 1 0", ok, grant_valid); end
        @(negedge clk);
        tests_run++; if ({uart_tx_start, uart_tx_data, grant_id} !== {1'b1, 8'h11, 3'd1}) begin tests_failed++; $display("[TB] FAIL rel_next: got %b/%h/%0d want 1/11/1", uart_tx_start, uart_tx_data, grant_id); end
        wait_busy_low(1, ok);
        pulse(4'd0, 32'd0, 4'b0001);
        tests_run++; if (grant_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rel_nonowner: got %b want 1", grant_valid); end
        pulse(4'd0, 32'd0, 4'b0010);
        tests_run++; if (grant_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rel_hold: got %b want 0", grant_valid); end
    endtask

    task automatic test_overflow;
        bit ok;
        int n_starts;
        pulse(4'b0100, 32'h0022_0000, 4'd0);
        wait_start(ok);
        pulse(4'b0001, 32'h0000_000A, 4'd0);
        tests_run++; if (err_overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_early: got %b want 0", err_overflow); end
        pulse(4'b0001, 32'h0000_000B, 4'd0);
        tests_run++; if (err_overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_flag: got %b want 1", err_overflow); end
        wait_busy_low(2, ok);
        pulse(4'd0, 32'd0, 4'b0100);
        wait_start(ok);
        tests_run++; if (!ok || uart_tx_data !== 8'h0A || grant_id !== 3'd0) begin tests_failed++; $display("[TB] FAIL ovf_first_byte: got ok=%b %h/%0d want 1 0a/0", ok, uart_tx_data, grant_id); end
        wait_busy_low(0, ok);
        n_starts = 0;
        repeat (40) begin
            @(negedge clk);
            if (uart_tx_start) n_starts++;
        end
        tests_run++; if (n_starts !== 0) begin tests_failed++; $display("[TB] FAIL ovf_dropped: got %0d extra starts want 0", n_starts); end
        pulse(4'd0, 32'd0, 4'b0001);
    endtask

    task automatic test_ack_timeout;
        bit ok;
        tie_low = 1'b1;
        pulse(4'b1000, 32'h7700_0000, 4'd0);
        wait_start(ok);
        repeat (14) @(negedge clk);
        tests_run++; if (!ok || err_ack_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL tmo_early: got ok=%b %b want 1 0", ok, err_ack_timeout); end
        @(negedge clk);
        tests_run++; if (err_ack_timeout !== 1'b1 || req_tx_busy[3] !== 1'b0 || grant_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL tmo_hold: got %b/%b/%b want 1/0/1", err_ack_timeout, req_tx_busy[3], grant_valid); end
        pulse(4'd0, 32'd0, 4'b1000);
        tests_run++; if (grant_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL tmo_idle: got %b want 0", grant_valid); end
        tie_low = 1'b0;
    endtask

    task automatic test_reset_mid_drain;
        bit ok;
        pulse(4'b0001, 32'h0000_0001, 4'd0);
        wait_start(ok);
        wait_busy_low(0, ok);
        pulse(4'd0, 32'd0, 4'b0001);
        pulse(4'b0100, 32'h0002_0000, 4'd0);
        wait_start(ok);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++; if ({req_tx_busy, uart_tx_start, uart_tx_data, grant_valid, grant_id} !== 17'd0) begin tests_failed++; $display("[TB] FAIL rst_mid_outputs: got %b want all zero", {req_tx_busy, uart_tx_start, uart_tx_data, grant_valid, grant_id}); end
        tests_run++; if ({err_overflow, err_ack_timeout} !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_mid_errors: got %b want 00", {err_overflow, err_ack_timeout}); end
        @(negedge clk);
        rst_n = 1'b1;
        pulse(4'b0011, 32'h0000_E1E0, 4'd0);
        wait_start(ok);
        tests_run++; if (!ok || uart_tx_data !== 8'hE0 || grant_id !== 3'd0) begin tests_failed++; $display("[TB] FAIL rst_mid_prio: got ok=%b %h/%0d want 1 e0/0", ok, uart_tx_data, grant_id); end
        wait_busy_low(0, ok);
        pulse(4'd0, 32'd0, 4'b0001);
        wait_start(ok);
        tests_run++; if (!ok || uart_tx_data !== 8'hE1 || grant_id !== 3'd1) begin tests_failed++; $display("[TB] FAIL rst_mid_second: got ok=%b %h/%0d want 1 e1/1", ok, uart_tx_data, grant_id); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        tie_low      = 1'b0;
        rst_n        = 1'b0;
        req_tx_start = 4'd0;
        req_tx_data  = 32'd0;
        req_release  = 4'd0;
        test_reset;
        test_contention;
        test_single;
        test_release;
        test_overflow;
        test_ack_timeout;
        test_reset_mid_drain;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among up to eight mode modules (setting, input, generate, display, compute). Each requester keeps the existing byte interface: it drives tx_data, pulses tx_start, and watches tx_busy. The arbiter buffers one byte per requester and grants the transmitter round-robin. Once granted, a requester keeps ownership across consecutive bytes until it releases or goes idle, so multi-byte messages such as "S 5 9 2\r\n" are never interleaved. It sits between the mode modules and uart_tx in the top level.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- LOCK_CYCLES, 16'd1000: idle cycles after the owner's last byte before ownership is dropped; legal range 1..65535.
- ACK_TIMEOUT, 4'd15: cycles to wait for uart_tx_busy to rise after a start pulse.
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- req_tx_start  input  NUM_REQ  per-requester one-cycle byte-launch pulse.
- req_tx_data  input  8*NUM_REQ  byte for requester i at [8i+7:8i]; sampled only when req_tx_start[i]=1.
- req_release  input  NUM_REQ  one-cycle pulse in which the owner gives up ownership.
- req_tx_busy  output  NUM_REQ  per-requester busy, registered.
- uart_tx_data  output  8  byte to the transmitter; held stable from the start pulse until the byte completes.
- uart_tx_start  output  1  one-cycle launch pulse to the transmitter.
- uart_tx_busy  input  1  transmitter busy.
- grant_valid  output  1  an owner exists.
- grant_id  output  3  current or most recent owner index.
- err_overflow  output  1  sticky; a start pulse arrived while that requester's slot was full.
- err_ack_timeout  output  1  sticky; the transmitter never raised busy.

## Operation
- Pending slots: each requester has pend_valid[i] and pend_data[i].
  - req_tx_start[i] with pend_valid[i]=0 loads the slot.
  - req_tx_start[i] with pend_valid[i]=1 drops the byte and sets err_overflow.
- Busy rule: req_tx_busy[i] = pend_valid[i] | (grant_valid & grant_id≠i) | (grant_valid & grant_id=i & state∈{SEND,DRAIN}).
- Arbitration is round-robin. Search starts at (last_owner+1) mod NUM_REQ over pend_valid. last_owner resets to NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE: no owner. If any slot is pending, pick the winner, set the owner, pulse uart_tx_start, drive uart_tx_data=pend_data[winner], clear that slot, go to SEND.
  - SEND: on uart_tx_busy=1 go to DRAIN. After ACK_TIMEOUT cycles without busy, set err_ack_timeout and go to HOLD.
  - DRAIN: on uart_tx_busy=0 go to HOLD and load lock_cnt=LOCK_CYCLES. If a release is deferred, go to IDLE instead.
  - HOLD:
    - If the owner's slot is pending, launch it as in IDLE (no arbitration) and go to SEND.
    - Else if the owner pulses release, or lock_cnt reaches 0, go to IDLE: last_owner←owner, grant_valid←0.
    - Else decrement lock_cnt.
    - Other requesters' pending slots wait.
- Release timing:
  - A release during SEND or DRAIN is latched and takes effect at the end of DRAIN.
  - Release from a non-owner, or while in IDLE, is ignored.
- Simultaneous events:
  - Start and release from the owner in the same HOLD cycle: the byte is captured, ownership drops, and the byte re-competes in IDLE at lowest priority.
  - Simultaneous starts in IDLE: all are captured and served in round-robin order.
- grant_id is held after release and updated on each new grant.

## Timing
- Reset values: state=IDLE, all slots empty, req_tx_busy=0, uart_tx_start=0, uart_tx_data=0, grant_valid=0, grant_id=0, both error flags 0, lock_cnt=0.
- Latency: req_tx_start[i] at cycle 0 → slot valid and req_tx_busy[i]=1 at cycle 1 → uart_tx_start=1 at cycle 2 (IDLE or owner HOLD).
- uart_tx_start is exactly one cycle wide and is never reissued before DRAIN exits.
- Byte-to-byte gap for the owner: a start pulse one cycle after req_tx_busy falls → the next uart_tx_start 2 cycles later.
- Reset mid-byte: everything clears immediately. The partially sent UART byte is not tracked.

## Test plan
- Single requester: r1 sends 0x53, 0x20 back-to-back → uart_tx_start at cycle 2 with 0x53, then 0x20 after DRAIN; grant_id=1; release after 1000 idle cycles.
- Contention: r0 and r2 pulse in the same cycle in IDLE → r0 is served first; r2 stays busy and is served after r0 times out or releases; r0's later bytes during HOLD precede r2's.
- Explicit release: owner r3 releases during DRAIN → IDLE right after DRAIN; pending r1 is granted next cycle; last_owner=3.
- Overflow: r0 pulses twice while its slot is pending → err_overflow=1; only the first byte is transmitted.
- Ack timeout: uart_tx_busy tied low → err_ack_timeout=1 after 15 cycles; the arbiter proceeds to HOLD and later IDLE.
- Reset mid-DRAIN: assert rst_n=0 → all outputs return to reset values in the same cycle; the next request is served from requester 0 priority.
